// File: rtl/shared_mem_sched.sv
// shared_mem_sched: time-shares one single-port register array between NREQ
// requesters. Each transaction takes IDLE (arbitrate) -> ACCESS -> RESP (ack).
// Build option: define SHARED_MEM_SCHED_FIXED_PRIO_EN for fixed lowest-index
// priority; by default arbitration is round-robin.
module shared_mem_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      we,
  input  logic [NREQ*AW-1:0]   addr,
  input  logic [NREQ*DW-1:0]   wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      ack,
  output logic [DW-1:0]        rdata,
  output logic                 busy,
  output logic [15:0]          txn_count
);

  localparam int unsigned IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   win;
  logic [IW-1:0]   pick_c;
  logic            any_c;
  logic            acc_we_c;
  logic [AW-1:0]   acc_addr_c;
  logic [DW-1:0]   acc_wdata_c;
  logic [DW-1:0]   mem [DEPTH];

`ifdef SHARED_MEM_SCHED_FIXED_PRIO_EN
  // Fixed priority: lowest-index active request wins
  always_comb begin
    pick_c = '0;
    any_c  = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[IW'(i)]) begin
        any_c  = 1'b1;
        pick_c = IW'(i);
      end
    end
  end
`else
  logic [IW-1:0] ptr;

  // Round-robin: first active request scanning upward from ptr, wrapping
  always_comb begin
    pick_c = '0;
    any_c  = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      int idx;
      idx = int'(ptr) + i;
      if (idx >= int'(NREQ)) idx = idx - int'(NREQ);
      if (!any_c && req[IW'(idx)]) begin
        any_c  = 1'b1;
        pick_c = IW'(idx);
      end
    end
  end

  // Pointer moves one past the winner as its transaction completes
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (state == S_RESP) begin
      ptr <= (win == IW'(NREQ - 1)) ? '0 : win + IW'(1);
    end
  end
`endif

  // Winner's request fields, held stable by the requester until ack
  always_comb begin
    acc_we_c    = we[win];
    acc_addr_c  = addr[32'(win) * AW +: AW];
    acc_wdata_c = wdata[32'(win) * DW +: DW];
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (any_c) state_nxt = S_ACCESS;
      S_ACCESS: state_nxt = S_RESP;
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Storage array write; contents intentionally not reset
  always_ff @(posedge clk) begin
    if (!reset && state == S_ACCESS && acc_we_c) begin
      mem[acc_addr_c] <= acc_wdata_c;
    end
  end

  // Registered outputs and winner latch
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt       <= '0;
      ack       <= '0;
      rdata     <= '0;
      busy      <= 1'b0;
      txn_count <= '0;
      win       <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          ack <= '0;
          if (any_c) begin
            win  <= pick_c;
            gnt  <= NREQ'(1) << pick_c;
            busy <= 1'b1;
          end
        end
        S_ACCESS: begin
          ack       <= gnt;
          txn_count <= txn_count + 16'd1;
          if (!acc_we_c) rdata <= mem[acc_addr_c];
        end
        S_RESP: begin
          ack  <= '0;
          gnt  <= '0;
          busy <= 1'b0;
        end
        default: begin
          ack  <= '0;
          gnt  <= '0;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shared_mem_sched.sv
// Self-checking bench for shared_mem_sched: transaction-level reference model,
// per-cycle compare, directed scenarios with literal expectations, random traffic.
module tb_shared_mem_sched;

  localparam int unsigned NREQ = 4;
  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 8;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ-1:0]      we = '0;
  logic [NREQ*AW-1:0]   addr = '0;
  logic [NREQ*DW-1:0]   wdata = '0;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      ack;
  logic [DW-1:0]        rdata;
  logic                 busy;
  logic [15:0]          txn_count;

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  shared_mem_sched #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .ack(ack), .rdata(rdata), .busy(busy), .txn_count(txn_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cycle);
    end
  endtask

  // ---------------- reference model (transaction timeline) ----------------
  // m_left = cycles of the current transaction still to run after this edge.
  int              m_left = 0;
  int              m_win = 0;
  int              m_ptr = 0;
  logic [NREQ-1:0] m_gnt = '0;
  logic [NREQ-1:0] m_ack = '0;
  logic [DW-1:0]   m_rdata = '0;
  bit              m_rdata_known = 1'b1;
  logic [15:0]     m_count = '0;
  logic [DW-1:0]   m_mem [32];
  bit              m_valid [32];

  always @(posedge clk) begin
    int k;
    logic [AW-1:0] a;
    if (reset) begin
      m_left = 0; m_ptr = 0; m_gnt = '0; m_ack = '0;
      m_rdata = '0; m_rdata_known = 1'b1; m_count = '0;
    end else if (m_left == 0) begin
      m_ack = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
`ifdef SHARED_MEM_SCHED_FIXED_PRIO_EN
        k = i;
`else
        k = (m_ptr + i) % int'(NREQ);
`endif
        if (req[k]) begin
          m_win = k; m_left = 2; m_gnt = NREQ'(1) << k;
          break;
        end
      end
    end else if (m_left == 2) begin
      a = addr[m_win*AW +: AW];
      if (we[m_win]) begin
        m_mem[a] = wdata[m_win*DW +: DW];
        m_valid[a] = 1'b1;
      end else begin
        m_rdata_known = m_valid[a];
        m_rdata = m_mem[a];
      end
      m_ack = m_gnt;
      m_count = m_count + 16'd1;
      m_left = 1;
    end else begin
      m_ack = '0; m_gnt = '0;
      m_ptr = (m_win + 1) % int'(NREQ);
      m_left = 0;
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (cycle > 0) begin
      chk("gnt", 32'(gnt), 32'(m_gnt));
      chk("ack", 32'(ack), 32'(m_ack));
      chk("busy", 32'(busy), 32'(m_left != 0));
      chk("txn_count", 32'(txn_count), 32'(m_count));
      chk("gnt_onehot0", 32'($countones(gnt) <= 1), 32'd1);
      if (m_rdata_known) chk("rdata", 32'(rdata), 32'(m_rdata));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input int k, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[k] = 1'b1; we[k] = w; addr[k*AW +: AW] = a; wdata[k*DW +: DW] = d;
  endtask

  task automatic wait_ack(input int k, output logic [DW-1:0] rd, output logic [15:0] cnt);
    bit seen;
    seen = 1'b0; rd = '0; cnt = '0;
    for (int n = 0; n < 30 && !seen; n++) begin
      @(negedge clk);
      if (ack[k]) begin
        seen = 1'b1; rd = rdata; cnt = txn_count; req[k] = 1'b0;
      end
    end
    chk("ack_wait", 32'(seen), 32'd1);
  endtask

  task automatic do_txn(input int k, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output logic [DW-1:0] rd, output logic [15:0] cnt);
    @(negedge clk);
    set_req(k, w, a, d);
    wait_ack(k, rd, cnt);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [DW-1:0] rd;
    logic [15:0]   cnt;
    int            last;
    int            n;
    int            order [2];
    bit            pend [NREQ];
    bit            seen;

    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(txn_count), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    reset = 1'b0;

    // Single write then read; also check request-to-ack latency of 2 cycles
    @(negedge clk);
    set_req(0, 1'b1, 5'd3, 8'hA5);
    last = cycle;
    wait_ack(0, rd, cnt);
    chk("wr_latency", 32'(cycle - last), 32'd2);
    chk("wr_cnt", 32'(cnt), 32'd1);
    do_txn(0, 1'b0, 5'd3, 8'h00, rd, cnt);
    chk("rd_data", 32'(rd), 32'hA5);
    chk("rd_cnt", 32'(cnt), 32'd2);

    // Reset to bring the pointer back to 0, then fairness under full load
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("rst2_cnt", 32'(txn_count), 32'd0);
    for (int k = 0; k < int'(NREQ); k++) set_req(k, 1'b1, AW'(16 + k), DW'(8'h40 + k));
    last = -1; n = 0;
    for (int t = 0; t < 60 && n < 8; t++) begin
      @(negedge clk);
      if (ack != '0) begin
`ifdef SHARED_MEM_SCHED_FIXED_PRIO_EN
        chk("rr_order", 32'(ack), 32'd1);
`else
        chk("rr_order", 32'(ack), 32'(1) << (n % 4));
`endif
        if (last >= 0) chk("rr_spacing", 32'(cycle - last), 32'd3);
        last = cycle; n++;
      end
    end
    chk("rr_num_acks", 32'(n), 32'd8);
    req = '0;
    repeat (4) @(negedge clk);

    // Pointer wrap: serve 2, then 0 and 3 together
    do_txn(2, 1'b1, 5'd20, 8'h22, rd, cnt);
    @(negedge clk);
    set_req(0, 1'b1, 5'd21, 8'h30);
    set_req(3, 1'b1, 5'd22, 8'h33);
    n = 0; order[0] = -1; order[1] = -1;
    for (int t = 0; t < 30 && n < 2; t++) begin
      @(negedge clk);
      for (int k = 0; k < int'(NREQ); k++) begin
        if (ack[k]) begin
          order[n] = k; n++; req[k] = 1'b0;
        end
      end
    end
`ifdef SHARED_MEM_SCHED_FIXED_PRIO_EN
    chk("wrap_first", 32'(order[0]), 32'd0);
    chk("wrap_second", 32'(order[1]), 32'd3);
`else
    chk("wrap_first", 32'(order[0]), 32'd3);
    chk("wrap_second", 32'(order[1]), 32'd0);
`endif

    // Early req drop during ACCESS
    @(negedge clk);
    set_req(1, 1'b1, 5'd7, 8'h3C);
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (gnt[1]) begin seen = 1'b1; req[1] = 1'b0; end
    end
    chk("drop_gnt_seen", 32'(seen), 32'd1);
    wait_ack(1, rd, cnt);
    do_txn(1, 1'b0, 5'd7, 8'h00, rd, cnt);
    chk("drop_rd_data", 32'(rd), 32'h3C);

    // Reset during ACCESS of a write suppresses the write and the ack
    do_txn(2, 1'b1, 5'd9, 8'h11, rd, cnt);
    @(negedge clk);
    set_req(2, 1'b1, 5'd9, 8'hFF);
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (gnt[2]) seen = 1'b1;
    end
    chk("rstmid_gnt_seen", 32'(seen), 32'd1);
    reset = 1'b1; req = '0;
    @(negedge clk);
    chk("rstmid_ack", 32'(ack), 32'd0);
    chk("rstmid_gnt", 32'(gnt), 32'd0);
    chk("rstmid_cnt", 32'(txn_count), 32'd0);
    reset = 1'b0;
    do_txn(2, 1'b0, 5'd9, 8'h00, rd, cnt);
    chk("rstmid_rd_data", 32'(rd), 32'h11);

    // Random traffic with early drops, back-to-back requests and rare resets
    for (int k = 0; k < int'(NREQ); k++) pend[k] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (reset) reset = 1'b0;
      for (int k = 0; k < int'(NREQ); k++) begin
        if (ack[k]) begin
          pend[k] = 1'b0;
          if ($urandom_range(1, 0) == 0) begin
            req[k] = 1'b0;
          end else begin
            set_req(k, 1'($urandom), AW'($urandom_range(7, 0)), DW'($urandom));
            pend[k] = 1'b1;
          end
        end else if (!pend[k] && !req[k] && $urandom_range(3, 0) == 0) begin
          set_req(k, 1'($urandom), AW'($urandom_range(7, 0)), DW'($urandom));
          pend[k] = 1'b1;
        end else if (pend[k] && gnt[k] && $urandom_range(7, 0) == 0) begin
          req[k] = 1'b0;
        end
      end
      if ($urandom_range(599, 0) == 0) begin
        reset = 1'b1; req = '0;
        for (int k = 0; k < int'(NREQ); k++) pend[k] = 1'b0;
      end
    end
    req = '0; reset = 1'b0;
    repeat (6) @(negedge clk);

    // Counter wrap: preload near the top while idle
    force dut.txn_count = 16'hFFFD;
    m_count = 16'hFFFD;
    #1 release dut.txn_count;
    do_txn(0, 1'b1, 5'd1, 8'h01, rd, cnt);
    chk("wrap_cnt_fffe", 32'(cnt), 32'hFFFE);
    do_txn(1, 1'b1, 5'd2, 8'h02, rd, cnt);
    chk("wrap_cnt_ffff", 32'(cnt), 32'hFFFF);
    do_txn(2, 1'b1, 5'd4, 8'h04, rd, cnt);
    chk("wrap_cnt_0000", 32'(cnt), 32'h0000);

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/shared_mem_sched.md
# shared_mem_sched

Round-robin scheduler that time-shares one single-port register array (2**AW words × DW bits) between NREQ requesters. Requesters present a read or write with a level request. The scheduler picks one winner, performs the access, returns a one-cycle acknowledge (with read data for reads), then re-arbitrates. It sits between the test-design masters and the shared storage array, so requesters never drive the array directly.

## Interface
- NREQ, 4: number of requesters (2..8).
- AW, 5: address width; array depth is 2**AW.
- DW, 8: data width.
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester level request.
- we  in  NREQ  per-requester write enable (1 = write, 0 = read).
- addr  in  NREQ*AW  packed addresses; requester k occupies bits [k*AW +: AW].
- wdata  in  NREQ*DW  packed write data; requester k occupies bits [k*DW +: DW].
- gnt  out  NREQ  one-hot grant; all zero when idle.
- ack  out  NREQ  one-hot, one-cycle completion pulse.
- rdata  out  DW  read data; valid while ack is high for a read.
- busy  out  1  high in ACCESS and RESP.
- txn_count  out  16  completed transactions, wraps 0xFFFF→0.

## Operation
- FSM states:
  - IDLE: if any req bit is high, latch the winner index and go to ACCESS; otherwise stay in IDLE.
  - ACCESS: perform the access for the winner, then go to RESP unconditionally.
  - RESP: pulse ack[winner], increment txn_count, update the pointer, then go to IDLE.
- Arbitration (round-robin): scan req starting at pointer ptr, upward, wrapping modulo NREQ. The first set bit wins.
  - ptr resets to 0.
  - In RESP, ptr ← (winner+1) mod NREQ.
- ACCESS samples the winner's we, addr and wdata at the end of the ACCESS cycle.
  - Write: array[addr] ← wdata; rdata unchanged.
  - Read: rdata ← array[addr].
- The requester must hold req, we, addr and wdata stable until its ack.
- If req drops after grant, the transaction still completes and ack is still issued; no abort path exists.
- If req is still high after ack, the requester is re-arbitrated in the next IDLE at the lowest round-robin priority.
- Array contents are not reset. Reading a never-written word returns an undefined value.
- Writes are visible to any later transaction, including a read of the same address in the immediately following transaction.
- gnt = onehot(winner) in ACCESS and RESP; 0 in IDLE.
- Reset values: state IDLE, gnt 0, ack 0, rdata 0, busy 0, txn_count 0, ptr 0.

## Timing
- Request sampled in cycle T (IDLE) → gnt high in T+1 (ACCESS) → ack and gnt high in T+2 (RESP) → IDLE in T+3.
- Read data is available with ack in T+2.
- Maximum throughput: one transaction per 3 cycles. The mandatory IDLE cycle after RESP is the arbitration slot.
- req arriving during ACCESS or RESP is not considered until the next IDLE.
- Reset asserted mid-transaction:
  - Takes priority at that edge; a write pending in ACCESS is not performed.
  - No ack is issued for the interrupted transaction; all outputs return to their reset values on the next edge.
- ack is never high for two consecutive cycles for the same requester.

## Configuration
- SHARED_MEM_SCHED_FIXED_PRIO_EN:
  - Defined: fixed priority; the lowest-index requester with req high always wins. ptr is not implemented.
  - Undefined (default): round-robin as described above.
- All other behaviour is identical in both builds.

## Test plan
- Single write then read: req[0]=1, we[0]=1, addr 5'd3, wdata 8'hA5. Expect ack[0] at T+2 and txn_count=1. Then read addr 3: ack[0] with rdata=8'hA5, txn_count=2.
- Round-robin fairness: hold req=4'b1111 continuously. Expect ack order 0,1,2,3,0,1… with acks spaced exactly 3 cycles apart and gnt always one-hot. Under SHARED_MEM_SCHED_FIXED_PRIO_EN, expect ack[0] only.
- Wrap of pointer: ptr=3 after serving requester 2, req=4'b1001. Expect requester 3 first, then requester 0.
- Early req drop: requester 1 deasserts req in the ACCESS cycle of its write to addr 7 (8'h3C). Expect ack[1] still pulses and a later read of addr 7 returns 8'h3C.
- Reset mid-operation: assert reset during ACCESS of a write of 8'hFF to addr 9 that was preceded by a write of 8'h11. Expect no ack, gnt=0, txn_count=0, and a later read of addr 9 returns 8'h11.
- Counter wrap: preload through 65535 transactions. Expect txn_count 0xFFFF → 0x0000 on the next ack.
